async_fifo_rd_streamer: RTL

Read-side consumer for the asynchronous FIFO, living entirely in the FIFO's read clock domain. It issues `rinc` pops against `rempty` and captures `rdata`, which has a fixed one-cycle read latency. It re-presents the words as a valid/ready stream with full throughput and lossless backpressure. It is the reader counterpart to the write-side driver and is the RTL end the read monitor observes.

---
 rtl/async_fifo_rtl_pkg.sv | 28 ++
 rtl/async_fifo_rd_streamer_skid.sv | 76 +++++++
 rtl/async_fifo_rd_streamer.sv | 60 ++++++
 3 files changed

// File: rtl/async_fifo_rtl_pkg.sv
// Shared types and defaults for the async FIFO read-side streamer.
// Holds the buffer occupancy enum and default widths.
package async_fifo_rtl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  function automatic logic [1:0] occ_words(
    input occ_state_e s
  );
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/async_fifo_rd_streamer_skid.sv
// Two-entry head/tail skid buffer with occupancy FSM.
// Ports: clk, rst_n, cap/cap_data in, m_valid/m_data/m_ready stream, occ out.
module stream_skid_buf
  import async_fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output occ_state_e            occ
);

  occ_state_e            state_q;
  occ_state_e            state_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;
  logic                  pop;

  assign m_valid = (state_q != EMPTY);
  assign m_data  = head_q;
  assign occ     = state_q;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (cap) begin
          state_d = ONE;
          head_d  = cap_data;
        end
      end
      ONE: begin
        if (cap && !pop) begin
          state_d = TWO;
          tail_d  = cap_data;
        end else if (!cap && pop) begin
          state_d = EMPTY;
        end else if (cap && pop) begin
          head_d = cap_data;
        end
      end
      TWO: begin
        // capture without pop is excluded by the pop rule upstream
        if (pop) begin
          head_d = tail_q;
          if (cap) tail_d  = cap_data;
          else     state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/async_fifo_rd_streamer.sv
// Read-domain FIFO consumer: issues rinc pops, captures rdata, streams out.
// Ports: rclk/rrst_n, en, rempty/rinc/rdata, m_valid/m_data/m_ready, rd_count, busy.
module async_fifo_rd_streamer
  import async_fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  occ_state_e occ;
  logic       infl_q;
  logic       pop;
  logic [2:0] load;

  assign pop = m_valid && m_ready;

  // words held or in flight once this cycle's pop retires
  assign load = {1'b0, occ_words(occ)}
              + {2'b0, infl_q}
              - {2'b0, pop};

  assign rinc = en && !rempty && (load < 3'd2);
  assign busy = (occ != EMPTY) || infl_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      infl_q   <= 1'b0;
      rd_count <= '0;
    end else begin
      infl_q <= rinc;
      if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .cap      (infl_q),
    .cap_data (rdata),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .occ      (occ)
  );

endmodule
